// File: rtl/c28soi_pm_control_lr_async_promip_access_master.sv
// Serial access master for the PM_CONTROL_LR_ASYNC promip register chain.
// Turns word-level host read/write requests into select/capture/shift/update/write sequences.
module c28soi_pm_control_lr_async_promip_access_master #(
    parameter int CTRL_LEN = 16,
    parameter int REF_LEN  = 32,
    parameter int STAT_LEN = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        serial_out,
    input  logic        sensor_ctrl_so,
    input  logic        ref_counter_so,
    input  logic        sensor_status_so,
    output logic        sensor_ctrl_select,
    output logic        ref_counter_select,
    output logic        sensor_status_select,
    output logic        capture,
    output logic        shift,
    output logic        update,
    output logic        write
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CAPTURE,
        S_SHIFT,
        S_UPDATE,
        S_RESP
    } state_t;

    localparam logic [5:0] L_CTRL = 6'(CTRL_LEN);
    localparam logic [5:0] L_REF  = 6'(REF_LEN);
    localparam logic [5:0] L_STAT = 6'(STAT_LEN);

    state_t      r_state, w_state;
    logic        r_write_op, w_write_op;
    logic [1:0]  r_addr, w_addr;
    logic [31:0] r_wdata, w_wdata;
    logic [5:0]  r_cnt, w_cnt;
    logic [31:0] r_shreg, w_shreg;

    logic        r_req_ready, w_req_ready;
    logic        r_rsp_valid, w_rsp_valid;
    logic [31:0] r_rsp_rdata, w_rsp_rdata;
    logic        r_rsp_err, w_rsp_err;
    logic        r_serial_out, w_serial_out;
    logic [2:0]  r_sel, w_sel;
    logic        r_capture, w_capture;
    logic        r_shift, w_shift;
    logic        r_update, w_update;
    logic        r_write, w_write;

    logic [5:0]  w_len;
    logic        w_so;
    logic [2:0]  w_sel_cur;

    always_comb begin
        w_len = L_STAT;
        w_so  = sensor_status_so;
        case (r_addr)
            2'd0: begin w_len = L_CTRL; w_so = sensor_ctrl_so; end
            2'd1: begin w_len = L_REF;  w_so = ref_counter_so; end
            default: begin w_len = L_STAT; w_so = sensor_status_so; end
        endcase
    end

    assign w_sel_cur = 3'b001 << r_addr;

    // Outputs are computed one cycle ahead so every pin comes straight from a flop.
    always_comb begin
        w_state      = r_state;
        w_write_op   = r_write_op;
        w_addr       = r_addr;
        w_wdata      = r_wdata;
        w_cnt        = r_cnt;
        w_shreg      = r_shreg;
        w_req_ready  = 1'b0;
        w_rsp_valid  = 1'b0;
        w_rsp_rdata  = 32'd0;
        w_rsp_err    = 1'b0;
        w_serial_out = 1'b0;
        w_sel        = 3'b000;
        w_capture    = 1'b0;
        w_shift      = 1'b0;
        w_update     = 1'b0;
        w_write      = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_req_ready = 1'b1;
                if (req_valid) begin
                    w_req_ready = 1'b0;
                    w_write_op  = req_write;
                    w_addr      = req_addr;
                    w_wdata     = req_wdata;
                    w_cnt       = 6'd0;
                    w_shreg     = 32'd0;
                    if (req_addr == 2'd3 || (req_write && req_addr == 2'd2)) begin
                        w_state     = S_RESP;
                        w_rsp_valid = 1'b1;
                        w_rsp_err   = 1'b1;
                    end else if (req_write) begin
                        w_state      = S_SHIFT;
                        w_shift      = 1'b1;
                        w_sel        = 3'b001 << req_addr;
                        w_serial_out = req_wdata[0];
                    end else begin
                        w_state   = S_CAPTURE;
                        w_capture = 1'b1;
                        w_sel     = 3'b001 << req_addr;
                    end
                end
            end
            S_CAPTURE: begin
                w_state = S_SHIFT;
                w_shift = 1'b1;
                w_sel   = w_sel_cur;
            end
            S_SHIFT: begin
                if (!r_write_op) begin
                    w_shreg[r_cnt[4:0]] = w_so;
                end
                if (r_cnt == w_len - 6'd1) begin
                    if (r_write_op) begin
                        w_state  = S_UPDATE;
                        w_update = 1'b1;
                        w_write  = 1'b1;
                        w_sel    = w_sel_cur;
                    end else begin
                        w_state     = S_RESP;
                        w_rsp_valid = 1'b1;
                        w_rsp_rdata = w_shreg;
                    end
                end else begin
                    w_cnt        = r_cnt + 6'd1;
                    w_shift      = 1'b1;
                    w_sel        = w_sel_cur;
                    w_serial_out = r_write_op & r_wdata[w_cnt[4:0]];
                end
            end
            S_UPDATE: begin
                w_state     = S_RESP;
                w_rsp_valid = 1'b1;
            end
            S_RESP: begin
                w_rsp_valid = 1'b1;
                w_rsp_rdata = r_rsp_rdata;
                w_rsp_err   = r_rsp_err;
                if (rsp_ready) begin
                    w_state     = S_IDLE;
                    w_rsp_valid = 1'b0;
                    w_rsp_rdata = 32'd0;
                    w_rsp_err   = 1'b0;
                    w_req_ready = 1'b1;
                end
            end
            default: begin
                w_state     = S_IDLE;
                w_req_ready = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_write_op   <= 1'b0;
            r_addr       <= 2'd0;
            r_wdata      <= 32'd0;
            r_cnt        <= 6'd0;
            r_shreg      <= 32'd0;
            r_req_ready  <= 1'b1;
            r_rsp_valid  <= 1'b0;
            r_rsp_rdata  <= 32'd0;
            r_rsp_err    <= 1'b0;
            r_serial_out <= 1'b0;
            r_sel        <= 3'b000;
            r_capture    <= 1'b0;
            r_shift      <= 1'b0;
            r_update     <= 1'b0;
            r_write      <= 1'b0;
        end else begin
            r_state      <= w_state;
            r_write_op   <= w_write_op;
            r_addr       <= w_addr;
            r_wdata      <= w_wdata;
            r_cnt        <= w_cnt;
            r_shreg      <= w_shreg;
            r_req_ready  <= w_req_ready;
            r_rsp_valid  <= w_rsp_valid;
            r_rsp_rdata  <= w_rsp_rdata;
            r_rsp_err    <= w_rsp_err;
            r_serial_out <= w_serial_out;
            r_sel        <= w_sel;
            r_capture    <= w_capture;
            r_shift      <= w_shift;
            r_update     <= w_update;
            r_write      <= w_write;
        end
    end

    assign req_ready            = r_req_ready;
    assign rsp_valid            = r_rsp_valid;
    assign rsp_rdata            = r_rsp_rdata;
    assign rsp_err              = r_rsp_err;
    assign serial_out           = r_serial_out;
    assign sensor_ctrl_select   = r_sel[0];
    assign ref_counter_select   = r_sel[1];
    assign sensor_status_select = r_sel[2];
    assign capture              = r_capture;
    assign shift                = r_shift;
    assign update               = r_update;
    assign write                = r_write;

endmodule

// File: tb/tb_c28soi_pm_control_lr_async_promip_access_master.sv
// Testbench: promip register-chain model plus a per-transaction expected-waveform model,
// compared against the access master on every cycle.
module tb_c28soi_pm_control_lr_async_promip_access_master;

    localparam int CTRL_LEN = 16;
    localparam int REF_LEN  = 32;
    localparam int STAT_LEN = 32;

    typedef struct packed {
        logic        reqReady;
        logic        rspValid;
        logic [31:0] rspRdata;
        logic        rspErr;
        logic        serialOut;
        logic [2:0]  sel;
        logic        cap;
        logic        shf;
        logic        upd;
        logic        wr;
    } outVec_t;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        serial_out;
    logic        sensorCtrlSo, refCounterSo, sensorStatusSo;
    logic        sensorCtrlSel, refCounterSel, sensorStatusSel;
    logic        strobeCapture, strobeShift, strobeUpdate, strobeWrite;

    int          compared   = 0;
    int          mismatched = 0;
    outVec_t     expQ[$];
    logic [31:0] modelPar [2];
    logic [31:0] statusIn;
    logic [31:0] lastSerial;

    logic [31:0] envSr  [3] = '{default: 32'h0};
    logic [31:0] envPar [2] = '{32'h0, 32'hFFFFFFFF};

    c28soi_pm_control_lr_async_promip_access_master #(
        .CTRL_LEN(CTRL_LEN), .REF_LEN(REF_LEN), .STAT_LEN(STAT_LEN)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .serial_out(serial_out),
        .sensor_ctrl_so(sensorCtrlSo), .ref_counter_so(refCounterSo), .sensor_status_so(sensorStatusSo),
        .sensor_ctrl_select(sensorCtrlSel), .ref_counter_select(refCounterSel),
        .sensor_status_select(sensorStatusSel),
        .capture(strobeCapture), .shift(strobeShift), .update(strobeUpdate), .write(strobeWrite)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int lenOf(input logic [1:0] a);
        case (a)
            2'd0: return CTRL_LEN;
            2'd1: return REF_LEN;
            default: return STAT_LEN;
        endcase
    endfunction

    function automatic logic [31:0] maskOf(input int n);
        if (n >= 32) return 32'hFFFFFFFF;
        return (32'h1 << n) - 32'h1;
    endfunction

    function automatic logic [31:0] shiftIn(input logic [31:0] sr, input int n);
        return (sr >> 1) | ({31'b0, serial_out} << (n - 1));
    endfunction

    // Register chain model: capture loads the parallel value, shift moves toward bit 0 (the so pin).
    always @(posedge clk) begin
        if (sensorCtrlSel) begin
            if (strobeCapture) envSr[0] <= envPar[0] & maskOf(CTRL_LEN);
            else if (strobeShift) envSr[0] <= shiftIn(envSr[0], CTRL_LEN);
            if (strobeUpdate && strobeWrite) envPar[0] <= envSr[0] & maskOf(CTRL_LEN);
        end
        if (refCounterSel) begin
            if (strobeCapture) envSr[1] <= envPar[1] & maskOf(REF_LEN);
            else if (strobeShift) envSr[1] <= shiftIn(envSr[1], REF_LEN);
            if (strobeUpdate && strobeWrite) envPar[1] <= envSr[1] & maskOf(REF_LEN);
        end
        if (sensorStatusSel) begin
            if (strobeCapture) envSr[2] <= statusIn & maskOf(STAT_LEN);
            else if (strobeShift) envSr[2] <= shiftIn(envSr[2], STAT_LEN);
        end
    end

    assign sensorCtrlSo   = envSr[0][0];
    assign refCounterSo   = envSr[1][0];
    assign sensorStatusSo = envSr[2][0];

    function automatic outVec_t idleVec();
        outVec_t v;
        v = '0;
        v.reqReady = 1'b1;
        return v;
    endfunction

    function automatic outVec_t dutVec();
        outVec_t v;
        v.reqReady  = req_ready;
        v.rspValid  = rsp_valid;
        v.rspRdata  = rsp_rdata;
        v.rspErr    = rsp_err;
        v.serialOut = serial_out;
        v.sel       = {sensorStatusSel, refCounterSel, sensorCtrlSel};
        v.cap       = strobeCapture;
        v.shf       = strobeShift;
        v.upd       = strobeUpdate;
        v.wr        = strobeWrite;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("[TB] FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        outVec_t e;
        if (expQ.size() > 0) e = expQ.pop_front();
        else e = idleVec();
        checkOutput("cycleOutputs", 64'(dutVec()), 64'(e));
    end

    // One transaction: enqueue the whole expected waveform, then drive junk requests and rsp_ready.
    task automatic applyStimulus(input logic wr, input logic [1:0] addr, input logic [31:0] wd,
                                 input int hold, input int abortCycle,
                                 output logic [31:0] rd, output logic er);
        int          n;
        int          lat;
        logic        legal;
        logic [31:0] readVal;
        outVec_t     v;
        n       = lenOf(addr);
        legal   = (addr != 2'd3) && !(wr && addr == 2'd2);
        readVal = ((addr == 2'd2) ? statusIn : modelPar[addr[0]]) & maskOf(n);
        rd = 32'd0;
        er = 1'b0;
        lastSerial = 32'd0;
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wd;
        @(posedge clk); #1;
        if (!legal) begin
            lat = 1;
        end else begin
            lat = n + 2;
            if (!wr) begin
                v = '0; v.cap = 1'b1; v.sel = 3'(1 << addr);
                expQ.push_back(v);
            end
            for (int k = 0; k < n; k++) begin
                v = '0; v.shf = 1'b1; v.sel = 3'(1 << addr);
                v.serialOut = wr ? wd[k] : 1'b0;
                expQ.push_back(v);
            end
            if (wr) begin
                v = '0; v.upd = 1'b1; v.wr = 1'b1; v.sel = 3'(1 << addr);
                expQ.push_back(v);
            end
        end
        v = '0;
        v.rspValid = 1'b1;
        v.rspErr   = !legal;
        v.rspRdata = (legal && !wr) ? readVal : 32'd0;
        repeat (hold + 1) expQ.push_back(v);
        for (int k = 1; k <= lat + hold; k++) begin
            if (k == abortCycle) begin
                #2 rst_n = 1'b0;
                expQ.delete();
                #1 checkOutput("asyncResetOutputs", 64'(dutVec()), 64'(idleVec()));
                repeat (2) @(posedge clk);
                #1 rst_n = 1'b1;
                req_valid = 1'b0;
                rsp_ready = 1'b0;
                return;
            end
            req_valid = 1'($urandom_range(0, 1));
            req_write = 1'($urandom_range(0, 1));
            req_addr  = 2'($urandom);
            req_wdata = $urandom;
            rsp_ready = (k < lat) ? 1'($urandom_range(0, 1)) : (k == lat + hold);
            if (strobeShift && k <= 32) lastSerial[k-1] = serial_out;
            if (k == lat) begin
                rd = rsp_rdata;
                er = rsp_err;
            end
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        if (legal && wr) modelPar[addr[0]] = wd & maskOf(n);
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = 2'd0;
        req_wdata = 32'd0;
        rsp_ready = 1'b0;
        statusIn  = 32'h12345678;
        modelPar  = '{32'h0, 32'hFFFFFFFF};
        repeat (3) @(posedge clk);
        #1;
        checkOutput("resetReqReady", 64'(req_ready), 64'(1));
        checkOutput("resetRspValid", 64'(rsp_valid), 64'(0));
        rst_n = 1'b1;
        @(posedge clk); #1;

        applyStimulus(1'b1, 2'd0, 32'h0000A5C3, 0, 0, rd, er);
        checkOutput("ctrlSerialSeq", 64'(lastSerial[15:0]), 64'(16'hA5C3));
        checkOutput("ctrlParallel", 64'(envPar[0]), 64'(32'h0000A5C3));
        checkOutput("ctrlWriteErr", 64'(er), 64'(0));

        applyStimulus(1'b0, 2'd1, 32'h0, 0, 0, rd, er);
        checkOutput("refReadData", 64'(rd), 64'(32'hFFFFFFFF));

        applyStimulus(1'b0, 2'd2, 32'h0, 0, 0, rd, er);
        checkOutput("statusReadData", 64'(rd), 64'(32'h12345678));

        applyStimulus(1'b1, 2'd2, 32'hCAFEF00D, 0, 0, rd, er);
        checkOutput("statusWriteErr", 64'(er), 64'(1));
        checkOutput("statusWriteData", 64'(rd), 64'(0));
        applyStimulus(1'b0, 2'd3, 32'h0, 0, 0, rd, er);
        checkOutput("addr3Err", 64'(er), 64'(1));
        checkOutput("addr3Data", 64'(rd), 64'(0));

        applyStimulus(1'b0, 2'd0, 32'h0, 5, 0, rd, er);
        checkOutput("ctrlReadHeld", 64'(rd), 64'(32'h0000A5C3));

        applyStimulus(1'b1, 2'd1, 32'h13579BDF, 0, 8, rd, er);
        checkOutput("refKeptAfterAbort", 64'(envPar[1]), 64'(32'hFFFFFFFF));
        @(posedge clk); #1;
        applyStimulus(1'b0, 2'd1, 32'h0, 0, 0, rd, er);
        checkOutput("refReadAfterAbort", 64'(rd), 64'(32'hFFFFFFFF));

        for (int t = 0; t < 40; t++) begin
            statusIn = $urandom;
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
            applyStimulus(1'($urandom_range(0, 1)), 2'($urandom), $urandom,
                          $urandom_range(0, 3), 0, rd, er);
        end

        repeat (3) @(posedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/c28soi_pm_control_lr_async_promip_access_master.md
# c28soi_pm_control_lr_async_promip_access_master

Serial access master for the PM_CONTROL_LR_ASYNC promip register chain (sensor control, reference counter, sensor status). It turns word-level read/write requests from the on-chip host into the per-register select, capture, shift, update and write sequence, plus the serial data stream. It sits between the host bus bridge and the promip register interface: it drives that interface's `serial_in` and control pins and receives its three `*_so` outputs.

## Interface
- `CTRL_LEN`, 16, sensor control register length in bits
- `REF_LEN`, 32, reference counter register length in bits
- `STAT_LEN`, 32, sensor status register length in bits (all lengths 1..32)

Ports:
- `clk  in  1` – single clock
- `rst_n  in  1` – asynchronous, active-low reset
- `req_valid  in  1` – request valid
- `req_ready  out  1` – request accepted when high together with `req_valid`
- `req_write  in  1` – 1 = write, 0 = read
- `req_addr  in  2` – 0 = sensor ctrl, 1 = ref counter, 2 = sensor status, 3 = reserved
- `req_wdata  in  32` – write data, LSB-aligned
- `rsp_valid  out  1` – response valid, held until `rsp_ready`
- `rsp_ready  in  1` – response consumed
- `rsp_rdata  out  32` – read data, zero-extended; 0 for writes and errors
- `rsp_err  out  1` – illegal access
- `serial_out  out  1` – to register interface `serial_in`
- `sensor_ctrl_so`, `ref_counter_so`, `sensor_status_so`  in  1 each – register serial outputs
- `sensor_ctrl_select`, `ref_counter_select`, `sensor_status_select`  out  1 each – one-hot register select
- `capture`, `shift`, `update`, `write`  out  1 each – register control strobes

## Operation
- FSM states: IDLE, CAPTURE, SHIFT, UPDATE, RESP.
- IDLE:
  - `req_ready` = 1.
  - On a handshake, latch op, addr and wdata.
  - Legal read (addr 0..2) -> CAPTURE.
  - Legal write (addr 0..1) -> SHIFT.
  - addr 3, or a write to addr 2 -> RESP with `rsp_err` = 1 and no register strobes.
- CAPTURE: one cycle, `capture` = 1 -> SHIFT.
- SHIFT:
  - Runs for exactly N cycles, N = length of the addressed register. A 6-bit counter runs 0..N-1.
  - `shift` = 1 on every cycle.
  - Write: `serial_out` = wdata[cnt], LSB first.
  - Read: `serial_out` = 0. The selected `*_so` is sampled into rdata[cnt] at the clock edge that ends each shift cycle.
  - After cnt = N-1: writes -> UPDATE, reads -> RESP.
- UPDATE: one cycle, `update` = 1 and `write` = 1 -> RESP.
- RESP:
  - `rsp_valid` = 1; `rsp_rdata` and `rsp_err` stay stable.
  - Leave for IDLE on `rsp_ready`.
  - Read data bits at index N and above are 0.
- Select: the matching select line is high from the first CAPTURE or SHIFT cycle through the last SHIFT or UPDATE cycle, and low in IDLE and RESP. At most one select is ever high.
- Control strobes are only high while a select is high. `capture`, `shift` and `update` are mutually exclusive.
- `req_wdata` bits at index N and above are ignored.

## Timing
- Every output is registered and glitch-free.
- Reset values: `req_ready` = 1. All other outputs = 0 (`rsp_valid`, `rsp_rdata`, `rsp_err`, `serial_out`, all selects and strobes).
- Cycle 0 is the accepting edge. Response latency, with `rsp_ready` held high:
  - Read: CAPTURE in cycle 1, SHIFT in cycles 2..N+1, `rsp_valid` from cycle N+2.
  - Write: SHIFT in cycles 1..N, UPDATE in cycle N+1, `rsp_valid` from cycle N+2.
  - Error: `rsp_valid` in cycle 1.
- Back-to-back: a new request can be accepted no earlier than the cycle after `rsp_valid` && `rsp_ready`. There is no overlap between transactions.
- Reset asserted mid-transaction: abort immediately, with all strobes and selects low asynchronously.
  - No UPDATE or `write` pulse is issued, so the target register's parallel output keeps its prior value.
  - After release, state is IDLE.
- `req_*` inputs are ignored outside IDLE.

## Test plan
- Write sensor ctrl, wdata 0x0000A5C3:
  - `shift` high for cycles 1..16, with `serial_out` = 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1.
  - `update` and `write` high in cycle 17; `rsp_valid` in cycle 18 with `rsp_err` = 0.
  - The register model's parallel output reads 0xA5C3.
- Read ref counter after reset, register model reset value all ones:
  - `capture` in cycle 1, 32 shift cycles, `rsp_rdata` = 0xFFFFFFFF in cycle 34.
  - No `update` or `write` pulse.
- Read sensor status with model parallel input 0x12345678:
  - `rsp_rdata` = 0x12345678.
  - Only `sensor_status_select` is ever high.
- Write to addr 2, then access addr 3:
  - Each returns `rsp_err` = 1 and `rsp_rdata` = 0 one cycle after acceptance.
  - Zero strobe activity.
- Hold `rsp_ready` low for 5 cycles after a read:
  - `rsp_valid` and `rsp_rdata` stay stable; `req_ready` stays 0.
  - The next request is accepted only after the `rsp_ready` handshake.
- Assert `rst_n` low during shift cycle 8 of a ref-counter write:
  - All outputs go to reset values without a clock.
  - No `update` pulse; model `ref_counter` is unchanged.
  - The next read completes normally.
